// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared memory-op codes, dmem FSM states and alignment helpers
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LW, SW:      return lo != 2'b00;
      LH, LHU, SH: return lo[0];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_subword_store(input mem_op_t op);
    return (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane extract/extend for loads, lane merge for stores
module dmem_lane_align
  import mips_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    merged_o    = word_i;
    load_data_o = word_i;
    case (op_i)
      LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU: load_data_o = {24'h0, byte_sel};
      LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
      LHU: load_data_o = {16'h0, half_sel};
      SW:  merged_o = wdata_i;
      SB:  merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SH:  merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// rtl/dmem_master.sv - data-memory master: request FSM with load extension and sub-word RMW
module dmem_master
  import mips_pkg::*;
#(
  parameter int DRAM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  dmem_state_t state_q;
  mem_op_t     op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        req_ready_q, resp_valid_q, resp_error_q, data_read_q, data_write_q;
  logic [31:0] resp_rdata_q, data_address_q, data_writedata_q;

  mem_op_t     req_op_d;
  logic        req_err_d;
  logic [31:0] merged_d, load_data_d;

  assign req_op_d  = mem_op_t'(req_op);
  assign req_err_d = is_misaligned(req_op_d, req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DRAM_WORDS));

  // Fed straight from the RAM so the RD cycle's word is used at the edge that ends it.
  dmem_lane_align u_lane_align (
    .op_i       (op_q),
    .addr_lo_i  (addr_lo_q),
    .word_i     (data_readdata),
    .wdata_i    (wdata_q),
    .merged_o   (merged_d),
    .load_data_o(load_data_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      op_q             <= LW;
      addr_lo_q        <= 2'b00;
      wdata_q          <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= '0;
      data_read_q      <= 1'b0;
      data_write_q     <= 1'b0;
      data_address_q   <= '0;
      data_writedata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op_d;
            addr_lo_q   <= req_addr[1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_op_d == SW) begin
              state_q          <= WR;
              data_write_q     <= 1'b1;
              data_address_q   <= {req_addr[31:2], 2'b00};
              data_writedata_q <= req_wdata;
            end else begin
              state_q        <= RD;
              data_read_q    <= 1'b1;
              data_address_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          data_read_q <= 1'b0;
          if (is_subword_store(op_q)) begin
            state_q          <= WR;
            data_write_q     <= 1'b1;
            data_writedata_q <= merged_d;
          end else begin
            state_q        <= RESP;
            resp_valid_q   <= 1'b1;
            resp_rdata_q   <= load_data_d;
            data_address_q <= '0;
          end
        end
        WR: begin
          state_q          <= RESP;
          data_write_q     <= 1'b0;
          data_writedata_q <= '0;
          data_address_q   <= '0;
          resp_valid_q     <= 1'b1;
          resp_rdata_q     <= '0;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;
  assign data_read      = data_read_q;
  assign data_write     = data_write_q;
  assign data_address   = data_address_q;
  assign data_writedata = data_writedata_q;

endmodule

// File: tb/tb_dmem_master.sv
// tb/tb_dmem_master.sv - scoreboard bench for dmem_master with a behavioural RAM
module tb_dmem_master;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] ram [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [31:0] pl_val = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic both_seen = 1'b0;
  logic addr_bad = 1'b0;
  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  exp_t e;
  int   a;

  dmem_master #(.DRAM_WORDS(4096)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .data_address  (data_address),
    .data_write    (data_write),
    .data_read     (data_read),
    .data_writedata(data_writedata),
    .data_readdata (data_readdata)
  );

  always #5 clk = ~clk;

  assign data_readdata = ram[data_address[13:2]];

  always @(posedge clk) begin
    if (data_write) ram[data_address[13:2]] <= data_writedata;
    else if (pl_en) ram[pl_idx] <= pl_val;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (data_read) rd_cnt = rd_cnt + 1;
    if (data_write) begin
      wr_cnt = wr_cnt + 1;
      last_wdata = data_writedata;
    end
    if (req_valid && req_ready && !reset) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) acc_q.delete();
    if (data_read && data_write) both_seen = 1'b1;
    if (req_ready && data_address != 0) addr_bad = 1'b1;
    if (resp_valid) begin
      chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0 && acc_q.size() != 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_error", 32'(resp_error), 32'(e.err));
        chk("resp_latency", 32'(cyc - a + 1), 32'(e.lat));
      end
    end
  end

  task automatic preload(input logic [11:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic hold);
    int n = 0;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err, input int lat,
                     input int nrd, input int nwr);
    int brd, bwr;
    brd = rd_cnt; bwr = wr_cnt;
    exp_q.push_back('{rdata, err, lat});
    send(op, addr, wdata, 1'b0);
    wait_done();
    chk("read_strobes", 32'(rd_cnt - brd), 32'(nrd));
    chk("write_strobes", 32'(wr_cnt - bwr), 32'(nwr));
  endtask

  initial begin
    preload(12'h100, 32'h8899AABB);
    preload(12'h008, 32'h11223344);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_strobes", {30'd0, data_read, data_write}, 32'd0);
    chk("rst_data_address", data_address, 32'd0);
    chk("rst_data_writedata", data_writedata, 32'd0);
    chk("rst_resp", {resp_rdata[30:0], resp_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(LB,  32'h403, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
    run(LBU, 32'h403, 32'h0, 32'h00000088, 1'b0, 2, 1, 0);
    run(LH,  32'h402, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    run(LHU, 32'h400, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0);
    run(LW,  32'h400, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);

    run(SH, 32'h402, 32'h00001234, 32'h0, 1'b0, 3, 1, 1);
    chk("sh_writedata", last_wdata, 32'h1234AABB);
    chk("sh_ram", ram[12'h100], 32'h1234AABB);
    run(SB, 32'h401, 32'h000000CC, 32'h0, 1'b0, 3, 1, 1);
    chk("sb_ram", ram[12'h100], 32'h1234CCBB);

    run(LW, 32'h401,  32'h0, 32'h0, 1'b1, 1, 0, 0);
    run(SW, 32'h4000, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
    run(LH, 32'h403,  32'h0, 32'h0, 1'b1, 1, 0, 0);
    run(SW, 32'h3FFC, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 0, 1);
    chk("sw_top_ram", ram[12'hFFF], 32'h5A5A5A5A);

    exp_q.push_back('{32'h0, 1'b0, 2});
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 2});
    send(SW, 32'h10, 32'hDEADBEEF, 1'b1);
    send(LW, 32'h10, 32'h0, 1'b0);
    wait_done();
    chk("b2b_accept_gap", 32'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 32'd3);

    send(SB, 32'h20, 32'h000000AA, 1'b0);
    @(negedge clk);
    chk("sb_in_wr", 32'(data_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {30'd0, data_read, data_write}, 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_address", data_address, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_ram", ram[12'h008], 32'h11223344);
    run(LW, 32'h20, 32'h0, 32'h11223344, 1'b0, 2, 1, 0);

    chk("never_both_strobes", 32'(both_seen), 32'd0);
    chk("idle_address_zero", 32'(addr_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
REQ-001 SHALL have parameter DRAM_WORDS, default 4096, giving the number of 32-bit words behind the data port; word indices at or above it are out of range.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit, which requests a memory operation.
REQ-005 SHALL have port req_ready, output, 1 bit, indicating the unit can accept a request.
REQ-006 SHALL have port req_op, input, 3 bits, carrying the mem_op_t code LW/LH/LHU/LB/LBU/SW/SH/SB.
REQ-007 SHALL have port req_addr, input, 32 bits, the byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits, the store data, with the sub-word value in the least-significant bits.
REQ-009 SHALL have port resp_valid, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32 bits, the extended load result, zero for stores and errors.
REQ-011 SHALL have port resp_error, output, 1 bit, flagging a misaligned or out-of-range request; valid with resp_valid.
REQ-012 SHALL have port data_address, output, 32 bits, a word-aligned byte address to the RAM.
REQ-013 SHALL have ports data_write and data_read, outputs, 1 bit each, the RAM strobes.
REQ-014 SHALL have port data_writedata, output, 32 bits, the full word to write.
REQ-015 SHALL have port data_readdata, input, 32 bits; the RAM returns it combinationally in the same cycle as data_read.

Function
REQ-016 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, and op, addr and wdata are registered at that edge.
REQ-018 SHALL treat a request as misaligned on these conditions:
- LW/SW with addr[1:0]!=0;
- LH/LHU/SH with addr[0]=1.
REQ-019 SHALL treat a request as out of range when addr[31:2] >= DRAM_WORDS.
REQ-020 SHALL route an errored request IDLE->RESP with resp_error=1, resp_rdata=0, and no data_read or data_write asserted.
REQ-021 SHALL follow these transitions:
- loads: IDLE->RD->RESP->IDLE;
- SW: IDLE->WR->RESP->IDLE;
- SH/SB: IDLE->RD->WR->RESP->IDLE, as read-modify-write.
REQ-022 SHALL, in RD, assert data_read=1 with data_address={addr[31:2],2'b00} and capture data_readdata at the end of that cycle.
REQ-023 SHALL, in WR, assert data_write=1 with the same address.
REQ-024 SHALL drive data_writedata in WR as follows:
- SW: wdata;
- SH/SB: the captured word with only the addressed lane(s) replaced.
REQ-025 SHALL use little-endian byte lanes: byte k = bits [8k+7:8k] for addr[1:0]=k, and halfword at addr[1]=h = bits [16h+15:16h].
REQ-026 SHALL extend load results as follows: LB/LH sign-extend to 32 bits, LBU/LHU zero-extend, LW returns the word unmodified.
REQ-027 SHALL assert resp_valid for exactly one cycle in RESP; latency from the accept edge to resp_valid is:
- error: 1 cycle;
- load/SW: 2 cycles;
- SH/SB: 3 cycles.
REQ-028 SHALL hold data_read and data_write at 0 outside RD and WR, never assert both in one cycle, and hold data_address at 0 when idle.
REQ-029 SHALL ignore req_valid while busy; back-to-back requests are accepted on the edge ending RESP+1 (IDLE), with no bypass.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-RMW, force state to IDLE immediately.
REQ-031 SHALL, on reset, drive these output values:
- resp_valid=0, resp_error=0, resp_rdata=0;
- data_read=0, data_write=0, data_address=0, data_writedata=0;
- req_ready=1.
REQ-032 SHALL complete no partial write after reset: a WR cycle interrupted by reset before the edge does not occur.

Structure
REQ-033 SHALL place enum mem_op_t and its op codes in shared package mips_pkg.
REQ-034 SHALL implement lane extract/merge and extension as combinational sub-module dmem_lane_align (inputs: op, addr[1:0], word, wdata; outputs: merged word, extended load data).

Verification
REQ-035 SHALL cover: RAM word 0x100 = 0x8899AABB; LB addr 0x403 -> rdata 0xFFFFFF88, resp_valid 2 cycles after accept; LBU addr 0x403 -> 0x00000088.
REQ-036 SHALL cover: SH addr 0x402 wdata 0x00001234 on 0x8899AABB -> one read then one write of 0x1234AABB; resp_valid 3 cycles after accept.
REQ-037 SHALL cover: LW addr 0x401 -> resp_error=1, rdata 0, no strobes; SW addr 0x4000 with DRAM_WORDS=4096 -> resp_error=1, no write.
REQ-038 SHALL cover: SW 0xDEADBEEF to 0x10 then LW 0x10 back-to-back with req_valid held high -> second accept in the IDLE after RESP, rdata 0xDEADBEEF.
REQ-039 SHALL cover: assert reset in WR of an SB -> strobes drop at once, RAM unchanged, req_ready=1, no resp_valid.
